// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS sequential divider (DIV/DIVU).
package mips_div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // Quotient reported for a zero divisor.
    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV0_QUOTIENT = {DIV_WIDTH_DEFAULT{1'b1}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor magnitude, keep the difference when it does not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o,
    output logic             trial_ok_o
);

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH+1:0] trial_s;

    // Trial subtraction with one extra bit so the borrow is never lost
    always_comb begin
        rem_sh_s   = {rem_i, quo_i[WIDTH-1]};
        trial_s    = {1'b0, rem_sh_s} - {2'b00, dmag_i};
        trial_ok_o = ~trial_s[WIDTH+1];
        if (trial_ok_o) begin
            rem_o = WIDTH'(trial_s);
        end else begin
            rem_o = WIDTH'(rem_sh_s);
        end
        quo_o = {quo_i[WIDTH-2:0], trial_ok_o};
    end

endmodule

// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider producing MIPS DIV/DIVU results
// (quotient -> LO, remainder -> HI). Operands are captured with start,
// converted to magnitudes, divided one bit per cycle, then sign-corrected.
// Optional build macro DIVIDER_EARLY_DONE_EN: when the divisor magnitude
// exceeds the dividend magnitude the iterations are skipped.
module mips_seq_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_quo_s;
    // The quotient LSB from the step already carries the trial decision.
    logic             trial_ok_unused_s;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i      (rem_q),
        .quo_i      (quo_q),
        .dmag_i     (dmag_q),
        .rem_o      (step_rem_s),
        .quo_o      (step_quo_s),
        .trial_ok_o (trial_ok_unused_s)
    );

    // Operand magnitudes: two's complement absolute value only in signed mode
    always_comb begin
        if (signed_q && dvd_q[WIDTH-1]) begin
            dvd_mag_s = ~dvd_q + WIDTH'(1);
        end else begin
            dvd_mag_s = dvd_q;
        end
        if (signed_q && dvs_q[WIDTH-1]) begin
            dvs_mag_s = ~dvs_q + WIDTH'(1);
        end else begin
            dvs_mag_s = dvs_q;
        end
    end

    // Next-state and datapath decisions for the divide sequence
    always_comb begin
        state_d     = state_q;
        signed_d    = signed_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                // done is registered, so its pulse lands while the FSM is
                // already back in IDLE; that cycle still belongs to DONE.
                if (start && !done_q) begin
                    signed_d = is_signed;
                    dvd_d    = dividend;
                    dvs_d    = divisor;
                    state_d  = INIT;
                end else begin
                    state_d  = IDLE;
                end
            end
            INIT: begin
                rem_d   = {WIDTH{1'b0}};
                quo_d   = dvd_mag_s;
                dmag_d  = dvs_mag_s;
                q_neg_d = signed_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                r_neg_d = signed_q & dvd_q[WIDTH-1];
                cnt_d   = CNT_W'(WIDTH);
                if (dvs_q == {WIDTH{1'b0}}) begin
                    state_d = FIX;
`ifdef DIVIDER_EARLY_DONE_EN
                end else if (dvs_mag_s > dvd_mag_s) begin
                    quo_d   = {WIDTH{1'b0}};
                    rem_d   = dvd_mag_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = FIX;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                if (dmag_q == {WIDTH{1'b0}}) begin
                    // Zero divisor: all-ones quotient, raw dividend back
                    quotient_d  = {WIDTH{1'b1}};
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                end else begin
                    if (q_neg_q) begin
                        quotient_d = ~quo_q + WIDTH'(1);
                    end else begin
                        quotient_d = quo_q;
                    end
                    if (r_neg_q) begin
                        remainder_d = ~rem_q + WIDTH'(1);
                    end else begin
                        remainder_d = rem_q;
                    end
                    dbz_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are registered one cycle behind the state
    always_comb begin
        busy_d = (state_q == INIT) || (state_q == RUN) || (state_q == FIX);
        done_d = (state_q == DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            signed_q    <= 1'b0;
            dvd_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            dmag_q      <= {WIDTH{1'b0}};
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            signed_q    <= signed_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
